// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store buffer sitting in front of the data memory.
// CPU stores (sw/sh/sb) are queued in a circular FIFO. The FIFO drains one entry
// per cycle in which the DM port is free, as a full-word read-modify-write.
// Loads own the DM port and see buffered bytes merged over the DM read data.
//
// Ports:
//   Clk, Reset                    clock, synchronous active-high reset
//   st_valid/st_addr/st_data/
//   st_be/st_pc, st_ready         store push interface (accepted when count < DEPTH)
//   ld_req, ld_addr, ld_data      load request and forwarded load word
//   dm_addr, dm_wr, dm_wdata,
//   dm_pc, dm_rdata               single-port DM interface (combinational read)
//   sb_empty                      no stores pending

// One byte lane: forwarding scan (oldest to newest, newest wins) and drain merge.
module dm_sb_lane #(
  parameter int DEPTH = 4
) (
  input  logic [7:0]            rdata_byte,
  input  logic [DEPTH-1:0]      hit,        // age order, bit 0 = oldest (head)
  input  logic [DEPTH-1:0][7:0] byte_in,    // age order
  input  logic                  head_be,
  input  logic [7:0]            head_byte,
  output logic [7:0]            fwd_byte,
  output logic [7:0]            wr_byte
);
  always_comb begin
    fwd_byte = rdata_byte;
    for (int k = 0; k < DEPTH; k++)
      if (hit[k]) fwd_byte = byte_in[k];
  end

  assign wr_byte = head_be ? head_byte : rdata_byte;
endmodule

module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic [31:0] dm_addr,
  output logic        dm_wr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata,
  output logic        sb_empty
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic push, drain;
  sb_entry_t head_ent;

  // Byte-offset bits are meaningless at word granularity.
  logic unused_lsb;
  assign unused_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready = count < (PTR_W+1)'(DEPTH);
  assign sb_empty = count == '0;
  assign push     = st_valid && st_ready;
  // Reset gates the drain so a reset cycle never emits a stray DM write.
  assign drain    = !Reset && !ld_req && (count != '0);
  assign head_ent = mem[head];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].be <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{addr: st_addr[31:2], data: st_data, be: st_be, pc: st_pc};
        tail      <= tail + 1'b1;
      end
      if (drain) head <= head + 1'b1;
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entries rearranged in age order (index 0 = head) for the forwarding scan.
  sb_entry_t                            age_ent [DEPTH];
  logic [DEPTH-1:0]                     age_vld;
  logic [NUM_LANES-1:0][DEPTH-1:0]      lane_hit;
  logic [NUM_LANES-1:0][DEPTH-1:0][7:0] lane_byte;
  logic [NUM_LANES-1:0][7:0]            fwd_w, wr_w;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] slot;
    assign slot       = head + PTR_W'(k);
    assign age_ent[k] = mem[slot];
    assign age_vld[k] = (PTR_W+1)'(k) < count;
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_ln
      assign lane_hit[l][k]  = age_vld[k] && (age_ent[k].addr == ld_addr[31:2]) && age_ent[k].be[l];
      assign lane_byte[l][k] = age_ent[k].data[8*l +: 8];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dm_sb_lane #(.DEPTH(DEPTH)) u_lane (
      .rdata_byte (dm_rdata[8*l +: 8]),
      .hit        (lane_hit[l]),
      .byte_in    (lane_byte[l]),
      .head_be    (head_ent.be[l]),
      .head_byte  (head_ent.data[8*l +: 8]),
      .fwd_byte   (fwd_w[l]),
      .wr_byte    (wr_w[l])
    );
  end

  assign ld_data = fwd_w;

  // DM port: load has priority, otherwise drain head, otherwise idle.
  always_comb begin
    dm_addr  = '0;
    dm_wr    = 1'b0;
    dm_wdata = '0;
    dm_pc    = '0;
    if (!Reset) begin
      if (ld_req) begin
        dm_addr = {ld_addr[31:2], 2'b00};
      end else if (drain) begin
        dm_addr  = {head_ent.addr, 2'b00};
        dm_wr    = 1'b1;
        dm_wdata = wr_w;
        dm_pc    = head_ent.pc;
      end
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Testbench for dm_store_buffer: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, st_pc = '0;
  logic [3:0]  st_be = '0;
  logic        st_ready;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data, dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        dm_wr, sb_empty;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .st_pc(st_pc), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .dm_rdata(dm_rdata), .sb_empty(sb_empty)
  );

  // Data memory environment: 256 words, combinational read.
  logic [31:0] dmem [256];
  bit inited = 1'b0;
  assign dm_rdata = dmem[dm_addr[9:2]];

  always @(posedge Clk) begin
    if (Reset && !inited) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
      dmem[8] <= 32'h1122_3344;
      inited  <= 1'b1;
    end else if (dm_wr === 1'b1) begin
      dmem[dm_addr[9:2]] <= dm_wdata;
    end
  end

  // Reference model: pending stores as a plain queue, oldest first.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = base;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge Clk) begin
    bit dr, pu;
    if (Reset) q.delete();
    else begin
      dr = !ld_req && q.size() > 0;
      pu = st_valid && q.size() < DEPTH;
      if (dr) void'(q.pop_front());
      if (pu) q.push_back('{st_addr, st_data, st_be, st_pc});
    end
  end

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge Clk) begin
    logic [31:0] e_addr, e_wdata, e_pc, e_ld;
    logic        e_wr;
    if (chk_en) begin
      e_addr = '0; e_wdata = '0; e_pc = '0; e_wr = 1'b0;
      if (!Reset) begin
        if (ld_req) e_addr = {ld_addr[31:2], 2'b00};
        else if (q.size() > 0) begin
          e_addr  = {q[0].addr[31:2], 2'b00};
          e_wr    = 1'b1;
          e_wdata = merge(dmem[q[0].addr[9:2]], q[0].data, q[0].be);
          e_pc    = q[0].pc;
        end
      end
      chk("m_st_ready", {31'd0, st_ready}, {31'd0, q.size() < DEPTH});
      chk("m_sb_empty", {31'd0, sb_empty}, {31'd0, q.size() == 0});
      chk("m_dm_wr", {31'd0, dm_wr}, {31'd0, e_wr});
      chk("m_dm_addr", dm_addr, e_addr);
      chk("m_dm_wdata", dm_wdata, e_wdata);
      chk("m_dm_pc", dm_pc, e_pc);
      if (ld_req && !Reset) begin
        e_ld = dmem[ld_addr[9:2]];
        foreach (q[k]) if (q[k].addr[31:2] == ld_addr[31:2]) e_ld = merge(e_ld, q[k].data, q[k].be);
        chk("m_ld_data", ld_data, e_ld);
      end
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic push_set(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] pc);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be; st_pc = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset for 2 cycles
    Reset = 1'b1;
    step(); chk_en = 1'b1;
    step(); Reset = 1'b0; #2;
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'h0);

    // sw, drains the next cycle
    push_set(32'h10, 32'h1234_5678, 4'b1111, 32'h3000);
    step(); st_valid = 1'b0; #2;
    chk("sw_dm_wr", {31'd0, dm_wr}, 32'd1);
    chk("sw_dm_addr", dm_addr, 32'h10);
    chk("sw_dm_wdata", dm_wdata, 32'h1234_5678);
    chk("sw_dm_pc", dm_pc, 32'h3000);
    step(); #2;
    chk("sw_empty", {31'd0, sb_empty}, 32'd1);
    chk("sw_idle_wr", {31'd0, dm_wr}, 32'd0);
    chk("sw_mem", dmem[4], 32'h1234_5678);

    // sb read-modify-write
    push_set(32'h21, 32'h0000_AB00, 4'b0010, 32'h3004);
    step(); st_valid = 1'b0; #2;
    chk("sb_dm_addr", dm_addr, 32'h20);
    chk("sb_dm_wdata", dm_wdata, 32'h1122_AB44);
    step(); #2;
    chk("sb_mem", dmem[8], 32'h1122_AB44);

    // Fill while a load holds the port, then drain in order
    ld_req = 1'b1; ld_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      push_set(32'h50 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'b1111, 32'h3100 + 32'(4*i));
      step();
    end
    #2;
    chk("full_st_ready", {31'd0, st_ready}, 32'd0);
    push_set(32'h60, 32'hB000_0005, 4'b1111, 32'h3200);
    step(); #2;
    chk("held_st_ready", {31'd0, st_ready}, 32'd0);
    chk("held_no_wr", {31'd0, dm_wr}, 32'd0);
    ld_req = 1'b0; #2;
    chk("drain0_addr", dm_addr, 32'h50);
    chk("drain0_pc", dm_pc, 32'h3100);
    step(); #2;
    chk("drain1_addr", dm_addr, 32'h54);
    chk("drain1_ready", {31'd0, st_ready}, 32'd1);
    step(); st_valid = 1'b0; #2;
    chk("drain2_addr", dm_addr, 32'h58);
    step(); #2;
    chk("drain3_addr", dm_addr, 32'h5C);
    step(); #2;
    chk("drain4_addr", dm_addr, 32'h60);
    chk("drain4_wdata", dm_wdata, 32'hB000_0005);
    step(); #2;
    chk("fill_empty", {31'd0, sb_empty}, 32'd1);
    chk("fill_mem0", dmem[20], 32'hA000_0000);
    chk("fill_mem3", dmem[23], 32'hA000_0003);
    chk("fill_mem4", dmem[24], 32'hB000_0005);

    // Forwarding: newest bytes win over older entry and DM
    ld_req = 1'b1; ld_addr = 32'h90;
    push_set(32'h40, 32'hCAFE_BABE, 4'b1111, 32'h3300);
    step();
    push_set(32'h40, 32'h0000_1111, 4'b0011, 32'h3304);
    step(); st_valid = 1'b0; ld_addr = 32'h41; #2;
    chk("fwd_ld_data", ld_data, 32'hCAFE_1111);
    chk("fwd_dm_addr", dm_addr, 32'h40);
    chk("fwd_no_wr", {31'd0, dm_wr}, 32'd0);
    ld_req = 1'b0;
    step(); step(); #2;
    chk("fwd_empty", {31'd0, sb_empty}, 32'd1);
    chk("fwd_mem", dmem[16], 32'hCAFE_1111);

    // Reset discards pending stores
    ld_req = 1'b1; ld_addr = 32'h90;
    for (int i = 0; i < 3; i++) begin
      push_set(32'hA0 + 32'(4*i), 32'hDEAD_0001 + 32'(i), 4'b1111, 32'h3400);
      step();
    end
    st_valid = 1'b0; ld_req = 1'b0; Reset = 1'b1; #2;
    chk("rst_pend_no_wr", {31'd0, dm_wr}, 32'd0);
    chk("rst_pend_addr", dm_addr, 32'h0);
    step(); Reset = 1'b0; #2;
    chk("rst_pend_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_pend_idle", {31'd0, dm_wr}, 32'd0);
    step(); step(); #2;
    chk("rst_pend_mem0", dmem[40], 32'h0);
    chk("rst_pend_mem2", dmem[42], 32'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
